// File: rtl/heartbeat_responder.sv
// Heartbeat responder: turns addressed heartbeat requests into acknowledge packets.
// It buffers pending replies in a small FIFO and filters loopback and duplicate requests.
module heartbeat_responder #(
  parameter int unsigned NODE_ID_WIDTH = 8,
  parameter int unsigned SEQ_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NODE_ID_WIDTH-1:0] this_node_id,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NODE_ID_WIDTH-1:0] req_src,
  input  logic [NODE_ID_WIDTH-1:0] req_dst,
  input  logic [SEQ_WIDTH-1:0]     req_seq,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [NODE_ID_WIDTH-1:0] resp_src,
  output logic [NODE_ID_WIDTH-1:0] resp_dst,
  output logic [SEQ_WIDTH-1:0]     resp_seq,
  output logic [CNT_WIDTH-1:0]     resp_count,
  output logic [CNT_WIDTH-1:0]     drop_count,
  output logic [CNT_WIDTH-1:0]     dup_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [NODE_ID_WIDTH-1:0] Broadcast = '1;
  localparam logic [CNT_WIDTH-1:0]     CntOne    = CNT_WIDTH'(1);
  localparam logic [PW-1:0]            PtrOne    = PW'(1);

  logic [NODE_ID_WIDTH-1:0] src_q [FIFO_DEPTH];
  logic [SEQ_WIDTH-1:0]     seq_q [FIFO_DEPTH];
  logic [PW-1:0]            wptr_q, rptr_q, used;
  logic [CNT_WIDTH-1:0]     resp_cnt_q, drop_cnt_q, dup_cnt_q;

  logic empty, full, pop, push, addressed, loopback, dup, drop_inc, dup_inc;

  assign used  = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign pop   = !empty && resp_ready;

  assign addressed = (req_dst == this_node_id) || (req_dst == Broadcast);
  assign loopback  = (req_src == this_node_id);

  // The head is still a live entry here even when it is popped this cycle.
  always_comb begin
    dup = 1'b0;
    for (int k = 0; k < int'(FIFO_DEPTH); k++) begin
      if ((PW'(k) < used) &&
          (src_q[rptr_q[AW-1:0] + AW'(k)] == req_src) &&
          (seq_q[rptr_q[AW-1:0] + AW'(k)] == req_seq)) begin
        dup = 1'b1;
      end
    end
  end

  always_comb begin
    push     = 1'b0;
    drop_inc = 1'b0;
    dup_inc  = 1'b0;
    if (req_valid && addressed) begin
      if (loopback)            drop_inc = 1'b1;
      else if (dup)            dup_inc  = 1'b1;
      else if (full && !pop)   drop_inc = 1'b1;
      else                     push     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      resp_cnt_q <= '0;
      drop_cnt_q <= '0;
      dup_cnt_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        src_q[i] <= '0;
        seq_q[i] <= '0;
      end
    end else begin
      if (push) begin
        src_q[wptr_q[AW-1:0]] <= req_src;
        seq_q[wptr_q[AW-1:0]] <= req_seq;
        wptr_q                <= wptr_q + PtrOne;
      end
      if (pop) rptr_q <= rptr_q + PtrOne;
      if (pop && (resp_cnt_q != '1))      resp_cnt_q <= resp_cnt_q + CntOne;
      if (drop_inc && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CntOne;
      if (dup_inc && (dup_cnt_q != '1))   dup_cnt_q  <= dup_cnt_q + CntOne;
    end
  end

  assign req_ready  = 1'b1;
  assign resp_valid = !empty;
  assign resp_src   = this_node_id;
  assign resp_dst   = src_q[rptr_q[AW-1:0]];
  assign resp_seq   = seq_q[rptr_q[AW-1:0]];
  assign resp_count = resp_cnt_q;
  assign drop_count = drop_cnt_q;
  assign dup_count  = dup_cnt_q;

endmodule

// File: tb/tb_heartbeat_responder.sv
// Bench for heartbeat_responder: directed scenarios plus random traffic against a queue model.
module tb_heartbeat_responder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  this_node_id;
  logic        req_valid, req_ready, resp_valid, resp_ready;
  logic [7:0]  req_src, req_dst, req_seq, resp_src, resp_dst, resp_seq;
  logic [15:0] resp_count, drop_count, dup_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of {src, seq} plus counters.
  logic [15:0] mq[$];
  int m_resp, m_drop, m_dup;

  always #5 clk = ~clk;

  heartbeat_responder dut (
    .clk(clk), .rst(rst), .this_node_id(this_node_id),
    .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src),
    .req_dst(req_dst), .req_seq(req_seq),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_src(resp_src),
    .resp_dst(resp_dst), .resp_seq(resp_seq),
    .resp_count(resp_count), .drop_count(drop_count), .dup_count(dup_count)
  );

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_edge();
    bit hit, full, pop, addr;
    logic [15:0] tmp;
    if (rst) begin
      mq.delete();
      m_resp = 0; m_drop = 0; m_dup = 0;
      return;
    end
    pop  = (mq.size() != 0) && resp_ready;
    full = (mq.size() == DEPTH);
    hit  = 1'b0;
    foreach (mq[i]) if (mq[i] == {req_src, req_seq}) hit = 1'b1;
    addr = (req_dst == this_node_id) || (req_dst == 8'hFF);
    if (pop) begin
      tmp = mq.pop_front();
      m_resp = sat(m_resp);
    end
    if (req_valid && addr) begin
      if (req_src == this_node_id)  m_drop = sat(m_drop);
      else if (hit)                 m_dup  = sat(m_dup);
      else if (full && !pop)        m_drop = sat(m_drop);
      else                          mq.push_back({req_src, req_seq});
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled there too.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [7:0] s, input logic [7:0] d,
                       input logic [7:0] q);
    req_valid = v; req_src = s; req_dst = d; req_seq = q;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || resp_dst !== 8'h00 || resp_seq !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%h s=%h want 0/00/00", resp_valid, resp_dst, resp_seq);
    end
    n_cmp++;
    if (resp_count !== 16'd0 || drop_count !== 16'd0 || dup_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", resp_count, drop_count, dup_count);
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL req_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_basic();
    resp_ready = 1'b1;
    drive(1, 8'h12, 8'h05, 8'h07);
    step();
    drive(0, 8'h00, 8'h00, 8'h00);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_src !== 8'h05 || resp_dst !== 8'h12 || resp_seq !== 8'h07) begin
      n_err++;
      $display("FAIL basic_resp: got v=%b src=%h dst=%h seq=%h want 1/05/12/07",
               resp_valid, resp_src, resp_dst, resp_seq);
    end
    step();
    n_cmp++;
    if (resp_count !== 16'(m_resp) || resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_count: got cnt=%0d v=%b want %0d/0", resp_count, resp_valid, m_resp);
    end
  endtask

  task automatic test_filter();
    resp_ready = 1'b1;
    drive(1, 8'h12, 8'h09, 8'h01);
    step();
    drive(0, 8'h00, 8'h00, 8'h00);
    n_cmp++;
    if (resp_valid !== 1'b0 || drop_count !== 16'(m_drop) || dup_count !== 16'(m_dup)) begin
      n_err++;
      $display("FAIL ignore_misaddr: got v=%b drop=%0d dup=%0d want 0/%0d/%0d",
               resp_valid, drop_count, dup_count, m_drop, m_dup);
    end
    drive(1, 8'h20, 8'hFF, 8'h01);
    step();
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_dst !== 8'h20 || resp_seq !== 8'h01) begin
      n_err++;
      $display("FAIL broadcast: got v=%b dst=%h seq=%h want 1/20/01", resp_valid, resp_dst, resp_seq);
    end
    drive(1, 8'h05, 8'h05, 8'h02);
    step();
    drive(0, 8'h00, 8'h00, 8'h00);
    n_cmp++;
    if (drop_count !== 16'(m_drop) || resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL loopback: got drop=%0d v=%b want %0d/0", drop_count, resp_valid, m_drop);
    end
  endtask

  task automatic test_overflow();
    resp_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1, 8'h40, 8'h05, 8'(i));
      step();
    end
    drive(0, 8'h00, 8'h00, 8'h00);
    n_cmp++;
    if (drop_count !== 16'(m_drop)) begin
      n_err++; $display("FAIL overflow_drop: got %0d want %0d", drop_count, m_drop);
    end
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_seq !== mq[0][7:0]) begin
        n_err++;
        $display("FAIL overflow_drain[%0d]: got v=%b seq=%h want 1/%h", i, resp_valid, resp_seq,
                 mq[0][7:0]);
      end
      step();
    end
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_err++; $display("FAIL overflow_empty: got v=%b want 0", resp_valid);
    end
  endtask

  task automatic test_full_push_pop();
    int d0;
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'h41, 8'h05, 8'(8'h10 + i));
      step();
    end
    d0 = m_drop;
    resp_ready = 1'b1;
    drive(1, 8'h41, 8'h05, 8'h14);
    step();
    drive(0, 8'h00, 8'h00, 8'h00);
    n_cmp++;
    if (drop_count !== 16'(d0) || resp_seq !== 8'h11) begin
      n_err++;
      $display("FAIL full_push_pop: got drop=%0d seq=%h want %0d/11", drop_count, resp_seq, d0);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_seq !== mq[0][7:0]) begin
        n_err++;
        $display("FAIL full_drain[%0d]: got v=%b seq=%h want 1/%h", i, resp_valid, resp_seq,
                 mq[0][7:0]);
      end
      step();
    end
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_err++; $display("FAIL full_empty: got v=%b want 0", resp_valid);
    end
  endtask

  task automatic test_dup();
    int u0;
    resp_ready = 1'b0;
    drive(1, 8'h12, 8'h05, 8'h30);
    step(); step();
    drive(0, 8'h00, 8'h00, 8'h00);
    n_cmp++;
    if (dup_count !== 16'(m_dup) || resp_valid !== 1'b1) begin
      n_err++; $display("FAIL dup_count: got %0d v=%b want %0d/1", dup_count, resp_valid, m_dup);
    end
    resp_ready = 1'b1;
    step();
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_err++; $display("FAIL dup_single: got v=%b want 0", resp_valid);
    end
    u0 = m_dup;
    resp_ready = 1'b0;
    drive(1, 8'h12, 8'h05, 8'h30);
    step();
    drive(0, 8'h00, 8'h00, 8'h00);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_seq !== 8'h30 || dup_count !== 16'(u0)) begin
      n_err++;
      $display("FAIL dup_requeue: got v=%b seq=%h dup=%0d want 1/30/%0d", resp_valid, resp_seq,
               dup_count, u0);
    end
    resp_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1, 8'h50, 8'h05, 8'(i));
      step();
    end
    drive(0, 8'h00, 8'h00, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || resp_count !== 16'd0 || drop_count !== 16'd0 ||
        dup_count !== 16'd0) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b %0d/%0d/%0d want 0 0/0/0", resp_valid, resp_count,
               drop_count, dup_count);
    end
    drive(1, 8'h12, 8'h05, 8'h44);
    step();
    drive(0, 8'h00, 8'h00, 8'h00);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_dst !== 8'h12 || resp_seq !== 8'h44) begin
      n_err++;
      $display("FAIL after_reset: got v=%b dst=%h seq=%h want 1/12/44", resp_valid, resp_dst,
               resp_seq);
    end
    resp_ready = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic [7:0] srcs [4];
    logic [7:0] dsts [3];
    srcs[0] = 8'h05; srcs[1] = 8'h12; srcs[2] = 8'h13; srcs[3] = 8'h20;
    dsts[0] = 8'h05; dsts[1] = 8'hFF; dsts[2] = 8'h09;
    for (int c = 0; c < 400; c++) begin
      n_cmp++;
      if (resp_valid !== (mq.size() != 0)) begin
        n_err++;
        $display("FAIL rand_valid[%0d]: got %b want %b", c, resp_valid, mq.size() != 0);
      end else if (mq.size() != 0) begin
        n_cmp++;
        if (resp_dst !== mq[0][15:8] || resp_seq !== mq[0][7:0] || resp_src !== 8'h05) begin
          n_err++;
          $display("FAIL rand_head[%0d]: got %h/%h/%h want 05/%h", c, resp_src, resp_dst,
                   resp_seq, mq[0]);
        end
      end
      n_cmp++;
      if (resp_count !== 16'(m_resp) || drop_count !== 16'(m_drop) ||
          dup_count !== 16'(m_dup)) begin
        n_err++;
        $display("FAIL rand_counts[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", c, resp_count,
                 drop_count, dup_count, m_resp, m_drop, m_dup);
      end
      drive($urandom_range(0, 3) != 0, srcs[$urandom_range(0, 3)], dsts[$urandom_range(0, 2)],
            8'($urandom_range(0, 3)));
      resp_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drive(0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    this_node_id = 8'h05;
    rst          = 1'b1;
    resp_ready   = 1'b0;
    drive(0, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_basic();
    test_filter();
    test_overflow();
    test_full_push_pop();
    test_dup();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
